noc_eject_port: RTL and testbench

- Receiving end of a router output port. Sits between one router output (odata/ovalid/ovch) and the local core.
- Accepts flits into per-VC FIFOs and returns per-VC ready (iack) and lock (ilck) to the router.
- Tracks HEAD/DATA/TAIL sequencing per VC and checks destination against its own coordinates.
- Hands whole packets to the core over a valid/ready stream without interleaving VCs mid-packet.

---
 rtl/noc_eject_port.sv | 240 ++++++++++++++++++++++++
 tb/tb_noc_eject_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_eject_port.sv
// noc_eject_port: receiving end of a router output port, feeding the local core.
//
// Flits are pushed into one FIFO per virtual channel. Per-VC ready (oack) and
// lock (olck) go back to the router. HEAD/DATA/TAIL ordering is tracked per VC,
// and HEAD destinations are checked against {my_xpos, my_ypos}. Whole packets
// are handed to the core over a valid/ready stream, one VC at a time, with
// round-robin selection between packets.
//
// Flit layout: [34:32] type, [31:10] spec, [9:8] vch, [7:4] src, [3:0] dst.
// Type codes: 3'd1 HEAD, 3'd2 DATA, 3'd3 TAIL; any other code is illegal.
//
// Ports:
//   clk, rst_                 clock, asynchronous active-high reset
//   idata, ivalid, ivch       flit from the router
//   oack[NVC]                 per-VC ready to the router (FIFO not full)
//   olck[NVC]                 per-VC lock to the router (packet open)
//   my_xpos, my_ypos          own coordinates
//   pkt_data, pkt_vch         flit to the core and its VC
//   pkt_valid, pkt_ready      core handshake
//   pkt_sof, pkt_eof          pkt_data is HEAD / TAIL
//   err_seq, err_dst, err_ovf one-cycle error pulses
//   pkt_cnt, flit_cnt         saturating delivery counters (EJECT_STATS_EN only)
//
// Build option: define EJECT_STATS_EN to add the pkt_cnt/flit_cnt counters.
//
// Output FSM states:
//   state    | meaning
//   S_IDLE   | no packet in progress; pick next VC with a HEAD, drop orphans
//   S_STREAM | forwarding the packet of VC cur_q until its TAIL is popped

module noc_eject_port #(
  parameter int DATA_W = 35,
  parameter int NVC    = 2,
  parameter int VCW    = 1,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DATA_W-1:0] idata,
  input  logic              ivalid,
  input  logic [VCW-1:0]    ivch,
  output logic [NVC-1:0]    oack,
  output logic [NVC-1:0]    olck,
  input  logic [1:0]        my_xpos,
  input  logic [1:0]        my_ypos,
  output logic [DATA_W-1:0] pkt_data,
  output logic [VCW-1:0]    pkt_vch,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              pkt_sof,
  output logic              pkt_eof,
  output logic              err_seq,
  output logic              err_dst,
  output logic              err_ovf
`ifdef EJECT_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       flit_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] T_HEAD = 3'd1;
  localparam logic [2:0] T_DATA = 3'd2;
  localparam logic [2:0] T_TAIL = 3'd3;

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  logic [DATA_W-1:0] mem    [NVC][DEPTH];
  logic [PW-1:0]     wr_ptr [NVC];
  logic [PW-1:0]     rd_ptr [NVC];
  logic [CW-1:0]     count  [NVC];
  logic [2:0]        head_type [NVC];
  logic [NVC-1:0]    open_q;

  state_t            state_q, state_d;
  logic [VCW-1:0]    cur_q, cur_d;
  logic [VCW-1:0]    rr_q, rr_d;

  logic              push, set_open, clr_open;
  logic              seq_err, dst_err, ovf_err;
  logic [NVC-1:0]    pop;
  logic              core_pop;
  logic              core_tail;
  logic              found;
  logic [2:0]        in_type;

  // Ready depends on registered occupancy only, so reset restores it at once.
  always_comb begin
    for (int v = 0; v < NVC; v++) begin
      oack[v]      = (count[v] != CW'(DEPTH));
      head_type[v] = mem[v][rd_ptr[v]][DATA_W-1 -: 3];
    end
  end

  assign olck    = open_q;
  assign in_type = idata[DATA_W-1 -: 3];

  // Input acceptance and sequencing checks. A full VC drops the flit without
  // touching the packet state of that VC.
  always_comb begin
    push     = 1'b0;
    set_open = 1'b0;
    clr_open = 1'b0;
    seq_err  = 1'b0;
    dst_err  = 1'b0;
    ovf_err  = 1'b0;
    if (ivalid) begin
      if (!oack[ivch]) begin
        ovf_err = 1'b1;
      end else begin
        case (in_type)
          T_HEAD: begin
            push     = 1'b1;
            set_open = 1'b1;
            seq_err  = open_q[ivch];
            dst_err  = (idata[3:0] != {my_xpos, my_ypos});
          end
          T_DATA: begin
            if (open_q[ivch]) push = 1'b1;
            else              seq_err = 1'b1;
          end
          T_TAIL: begin
            if (open_q[ivch]) begin
              push     = 1'b1;
              clr_open = 1'b1;
            end else begin
              seq_err = 1'b1;
            end
          end
          default: seq_err = 1'b1;
        endcase
      end
    end
  end

  // Output FSM: next state, pops and core-side outputs.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rr_d      = rr_q;
    pop       = '0;
    found     = 1'b0;
    core_pop  = 1'b0;
    core_tail = 1'b0;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    pkt_vch   = '0;
    pkt_sof   = 1'b0;
    pkt_eof   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Non-HEAD flits at a FIFO head here cannot belong to a packet the
        // core will ever see, so they are discarded.
        for (int i = 0; i < NVC; i++) begin
          if (count[i] != '0 && head_type[i] != T_HEAD) pop[i] = 1'b1;
        end
        for (int k = 0; k < NVC; k++) begin
          if (!found && count[(int'(rr_q) + k) % NVC] != '0 &&
              head_type[(int'(rr_q) + k) % NVC] == T_HEAD) begin
            found   = 1'b1;
            cur_d   = VCW'((int'(rr_q) + k) % NVC);
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (count[cur_q] != '0) begin
          pkt_valid = 1'b1;
          pkt_data  = mem[cur_q][rd_ptr[cur_q]];
          pkt_vch   = cur_q;
          pkt_sof   = (head_type[cur_q] == T_HEAD);
          pkt_eof   = (head_type[cur_q] == T_TAIL);
        end
        if (pkt_valid && pkt_ready) begin
          pop[cur_q] = 1'b1;
          core_pop   = 1'b1;
          if (pkt_eof) begin
            core_tail = 1'b1;
            state_d   = S_IDLE;
            rr_d      = (cur_q == VCW'(NVC - 1)) ? '0 : cur_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[ivch][wr_ptr[ivch]] <= idata;
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int v = 0; v < NVC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      open_q  <= '0;
      state_q <= S_IDLE;
      cur_q   <= '0;
      rr_q    <= '0;
      err_seq <= 1'b0;
      err_dst <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      for (int v = 0; v < NVC; v++) begin
        if (push && ivch == VCW'(v)) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])                  rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if ((push && ivch == VCW'(v)) && !pop[v])      count[v] <= count[v] + 1'b1;
        else if (!(push && ivch == VCW'(v)) && pop[v]) count[v] <= count[v] - 1'b1;
      end
      if (set_open)      open_q[ivch] <= 1'b1;
      else if (clr_open) open_q[ivch] <= 1'b0;
      state_q <= state_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      err_seq <= seq_err;
      err_dst <= dst_err;
      err_ovf <= ovf_err;
    end
  end

`ifdef EJECT_STATS_EN
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      pkt_cnt  <= '0;
      flit_cnt <= '0;
    end else begin
      if (core_pop && flit_cnt != 16'hFFFF)  flit_cnt <= flit_cnt + 16'd1;
      if (core_tail && pkt_cnt != 16'hFFFF)  pkt_cnt  <= pkt_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_noc_eject_port.sv
module tb_noc_eject_port;

  logic        clk = 1'b0;
  logic        rst_;
  logic [34:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic [1:0]  oack, olck;
  logic [1:0]  my_xpos, my_ypos;
  logic [34:0] pkt_data;
  logic [0:0]  pkt_vch;
  logic        pkt_valid, pkt_ready, pkt_sof, pkt_eof;
  logic        err_seq, err_dst, err_ovf;
`ifdef EJECT_STATS_EN
  logic [15:0] pkt_cnt, flit_cnt;
`endif

  noc_eject_port #(.DATA_W(35), .NVC(2), .VCW(1), .DEPTH(4)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .oack(oack), .olck(olck), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .pkt_data(pkt_data), .pkt_vch(pkt_vch), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof),
    .err_seq(err_seq), .err_dst(err_dst), .err_ovf(err_ovf)
`ifdef EJECT_STATS_EN
    , .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv;
    logic [34:0] din;
    logic        rdy;
    logic [1:0]  ack;
    logic [1:0]  lck;
    logic        pv;
    logic [34:0] pd;
    logic        sof;
    logic        eof;
    logic [2:0]  err;   // {seq, dst, ovf}
  } vec_t;

  vec_t        vecs[$];
  logic [34:0] push_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  int          total = 0;
  int          bad   = 0;

  function automatic logic [34:0] fl(input logic [2:0] t, input logic [21:0] sp,
                                     input logic [1:0] vc, input logic [3:0] dst);
    return {t, sp, vc, 4'h0, dst};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic iv, input logic [34:0] din,
                     input logic rdy, input logic [1:0] ack, input logic [1:0] lck,
                     input logic pv, input logic [34:0] pd, input logic sof,
                     input logic eof, input logic [2:0] err);
    vec_t v;
    v.name = nm; v.iv = iv; v.din = din; v.rdy = rdy; v.ack = ack; v.lck = lck;
    v.pv = pv; v.pd = pd; v.sof = sof; v.eof = eof; v.err = err;
    vecs.push_back(v);
  endtask

  // Drives push_q one flit per cycle and records every flit the core accepts,
  // stopping when exp_q is satisfied or the cycle budget runs out.
  task automatic run_stream(input string nm, input int budget);
    int cyc = 0;
    logic [34:0] d;
    got_q.delete();
    while ((got_q.size() < exp_q.size() || push_q.size() != 0) && cyc < budget) begin
      if (pkt_valid && pkt_ready) got_q.push_back({pkt_vch, pkt_data});
      if (push_q.size() != 0) begin
        d = push_q.pop_front();
        ivalid = 1'b1; ivch = d[8]; idata = d;
      end else begin
        ivalid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ivalid = 1'b0;
    check({nm, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_flit%0d", nm, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    logic [34:0] a_h, a_d, a_t, b_h, b_t, c_h, c_d4, c_d5, c_d6, c_d7, c_t8, e_d1, e_x, z;
    logic [34:0] p_h, p_t, q_h, q_t, r_h, r_t, h0, h1, d0, d1, t0, t1;
    logic [63:0] got, exp;

    a_h  = fl(3'd1, 22'ha, 2'd0, 4'b0101);
    a_d  = fl(3'd2, 22'hb, 2'd0, 4'b0101);
    a_t  = fl(3'd3, 22'hc, 2'd0, 4'b0101);
    b_h  = fl(3'd1, 22'h1, 2'd0, 4'b0110);
    b_t  = fl(3'd3, 22'h2, 2'd0, 4'b0110);
    c_h  = fl(3'd1, 22'h3, 2'd0, 4'b0101);
    c_d4 = fl(3'd2, 22'h4, 2'd0, 4'b0101);
    c_d5 = fl(3'd2, 22'h5, 2'd0, 4'b0101);
    c_d6 = fl(3'd2, 22'h6, 2'd0, 4'b0101);
    c_d7 = fl(3'd2, 22'h7, 2'd0, 4'b0101);
    c_t8 = fl(3'd3, 22'h8, 2'd0, 4'b0101);
    e_d1 = fl(3'd2, 22'h9, 2'd1, 4'b0101);
    e_x  = fl(3'd0, 22'hd, 2'd0, 4'b0101);
    z    = '0;

    //   name        iv  din   rdy ack    lck    pv  pd    sof eof err
    add("s1_head",   1, a_h,  1, 2'b11, 2'b01, 0, z,    0, 0, 3'b000);
    add("s1_data",   1, a_d,  1, 2'b11, 2'b01, 1, a_h,  1, 0, 3'b000);
    add("s1_tail",   1, a_t,  1, 2'b11, 2'b00, 1, a_d,  0, 0, 3'b000);
    add("s1_out_t",  0, z,    1, 2'b11, 2'b00, 1, a_t,  0, 1, 3'b000);
    add("s1_empty",  0, z,    1, 2'b11, 2'b00, 0, z,    0, 0, 3'b000);
    add("s2_baddst", 1, b_h,  1, 2'b11, 2'b01, 0, z,    0, 0, 3'b010);
    add("s2_tail",   1, b_t,  1, 2'b11, 2'b00, 1, b_h,  1, 0, 3'b000);
    add("s2_out_t",  0, z,    1, 2'b11, 2'b00, 1, b_t,  0, 1, 3'b000);
    add("s2_empty",  0, z,    1, 2'b11, 2'b00, 0, z,    0, 0, 3'b000);
    add("s3_f1",     1, c_h,  0, 2'b11, 2'b01, 0, z,    0, 0, 3'b000);
    add("s3_f2",     1, c_d4, 0, 2'b11, 2'b01, 1, c_h,  1, 0, 3'b000);
    add("s3_f3",     1, c_d5, 0, 2'b11, 2'b01, 1, c_h,  1, 0, 3'b000);
    add("s3_f4",     1, c_d6, 0, 2'b10, 2'b01, 1, c_h,  1, 0, 3'b000);
    add("s3_f5_ovf", 1, c_d7, 0, 2'b10, 2'b01, 1, c_h,  1, 0, 3'b001);
    add("s3_drain1", 0, z,    1, 2'b11, 2'b01, 1, c_d4, 0, 0, 3'b000);
    add("s3_drain2", 0, z,    1, 2'b11, 2'b01, 1, c_d5, 0, 0, 3'b000);
    add("s3_drain3", 0, z,    1, 2'b11, 2'b01, 1, c_d6, 0, 0, 3'b000);
    add("s3_drain4", 0, z,    1, 2'b11, 2'b01, 0, z,    0, 0, 3'b000);
    add("s3_tail",   1, c_t8, 1, 2'b11, 2'b00, 1, c_t8, 0, 1, 3'b000);
    add("s3_empty",  0, z,    1, 2'b11, 2'b00, 0, z,    0, 0, 3'b000);
    add("s4_orphan", 1, e_d1, 1, 2'b11, 2'b00, 0, z,    0, 0, 3'b100);
    add("s4_clear",  0, z,    1, 2'b11, 2'b00, 0, z,    0, 0, 3'b000);
    add("s4_badtyp", 1, e_x,  1, 2'b11, 2'b00, 0, z,    0, 0, 3'b100);
    add("s4_idle",   0, z,    1, 2'b11, 2'b00, 0, z,    0, 0, 3'b000);

    rst_ = 1'b1; idata = '0; ivalid = 1'b0; ivch = '0; pkt_ready = 1'b1;
    my_xpos = 2'd1; my_ypos = 2'd1;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;

    check("reset_state", {oack, olck, pkt_valid, pkt_data, pkt_sof, pkt_eof, err_seq, err_dst, err_ovf},
          {2'b11, 2'b00, 1'b0, 35'h0, 1'b0, 1'b0, 3'b000});

    foreach (vecs[i]) begin
      ivalid = vecs[i].iv; idata = vecs[i].din; ivch = vecs[i].din[8];
      pkt_ready = vecs[i].rdy;
      @(posedge clk); #1;
      got = {oack, olck, pkt_valid, pkt_data, pkt_vch, pkt_sof, pkt_eof, err_seq, err_dst, err_ovf};
      exp = {vecs[i].ack, vecs[i].lck, vecs[i].pv, vecs[i].pd, vecs[i].pd[8],
             vecs[i].sof, vecs[i].eof, vecs[i].err};
      check(vecs[i].name, got, exp);
    end
    ivalid = 1'b0;

    // Reset in the middle of a packet held by a stalled core.
    pkt_ready = 1'b0;
    push_q.push_back(a_h);
    push_q.push_back(a_d);
    run_stream("rst_prep", 10);
    check("pre_rst_valid", 64'(pkt_valid), 64'd1);
    rst_ = 1'b1;
    #1;
    check("rst_oack", 64'(oack), 64'(2'b11));
    check("rst_olck", 64'(olck), 64'(2'b00));
    check("rst_pvalid", 64'(pkt_valid), 64'd0);
`ifdef EJECT_STATS_EN
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    rst_ = 1'b0;
    pkt_ready = 1'b1;

    // Round 1: two packets interleaved flit-by-flit must come out whole.
    h0 = fl(3'd1, 22'h10, 2'd0, 4'b0101); h1 = fl(3'd1, 22'h20, 2'd1, 4'b0101);
    d0 = fl(3'd2, 22'h11, 2'd0, 4'b0101); d1 = fl(3'd2, 22'h21, 2'd1, 4'b0101);
    t0 = fl(3'd3, 22'h12, 2'd0, 4'b0101); t1 = fl(3'd3, 22'h22, 2'd1, 4'b0101);
    push_q = '{h0, h1, d0, d1, t0, t1};
    exp_q  = '{{1'b0, h0}, {1'b0, d0}, {1'b0, t0}, {1'b1, h1}, {1'b1, d1}, {1'b1, t1}};
    run_stream("interleave", 60);

    // Round 2: after a VC0 packet, VC1 wins even though VC0 has another HEAD.
    p_h = fl(3'd1, 22'h30, 2'd0, 4'b0101); p_t = fl(3'd3, 22'h31, 2'd0, 4'b0101);
    q_h = fl(3'd1, 22'h40, 2'd1, 4'b0101); q_t = fl(3'd3, 22'h41, 2'd1, 4'b0101);
    r_h = fl(3'd1, 22'h50, 2'd0, 4'b0101); r_t = fl(3'd3, 22'h51, 2'd0, 4'b0101);
    pkt_ready = 1'b0;
    push_q = '{p_h, p_t, q_h, q_t, r_h, r_t};
    run_stream("rr_fill", 20);
    check("rr_hold_data", 64'(pkt_data), 64'(p_h));
    pkt_ready = 1'b1;
    exp_q = '{{1'b0, p_h}, {1'b0, p_t}, {1'b1, q_h}, {1'b1, q_t}, {1'b0, r_h}, {1'b0, r_t}};
    run_stream("rr_order", 60);
    check("final_oack", 64'(oack), 64'(2'b11));
`ifdef EJECT_STATS_EN
    check("stats_pkt", 64'(pkt_cnt), 64'd5);
    check("stats_flit", 64'(flit_cnt), 64'd12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
